// File: rtl/gshare_ctr.sv
// gshare_ctr: gshare conditional-branch predictor.
//
// A pattern history table (PHT) of 2**BH_SIZE saturating counters is indexed
// by the speculative global history register (GHR) XORed with PC bits. The
// counter MSB is the predicted direction. Fetch receives the GHR snapshot that
// produced each prediction; at retire that snapshot comes back to train the
// same counter and, on a mispredict, to rebuild the GHR.
//
// Optional feature macro: GSHARE_CTR_BYPASS_EN
//   defined   - a prediction that hits the counter being trained this cycle
//               sees the post-training value.
//   undefined - a prediction always reads the registered counter.
//
// Ports:
//   clock          in   single clock
//   reset          in   synchronous, active-high
//   pred_en        in   fetch presents a conditional branch
//   pred_pc        in   PC of that branch
//   pred_valid     out  pred_taken / pred_ghr are meaningful
//   pred_taken     out  predicted direction (1 = taken)
//   pred_ghr       out  GHR used for this prediction
//   upd_en         in   a conditional branch retires
//   upd_pc         in   PC of the retiring branch
//   upd_ghr        in   pred_ghr captured for the retiring branch
//   upd_taken      in   resolved direction
//   upd_mispredict in   resolved direction differed from the prediction
//   ghr_out        out  current speculative GHR
module gshare_ctr #(
  parameter int BH_SIZE  = 8,
  parameter int CTR_BITS = 2,
  parameter int PC_LSB   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pred_en,
  input  logic [31:0]        pred_pc,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic [BH_SIZE-1:0] pred_ghr,
  input  logic               upd_en,
  input  logic [31:0]        upd_pc,
  input  logic [BH_SIZE-1:0] upd_ghr,
  input  logic               upd_taken,
  input  logic               upd_mispredict,
  output logic [BH_SIZE-1:0] ghr_out
);

  localparam int DEPTH = 1 << BH_SIZE;
  // Weakly-not-taken: one below the taken threshold.
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  // Saturating up/down step; the counter never wraps at either end.
  function automatic logic [CTR_BITS-1:0] ctr_step(
    input logic [CTR_BITS-1:0] ctr,
    input logic                up
  );
    if (up) return (ctr == '1) ? ctr : ctr + CTR_BITS'(1);
    else    return (ctr == '0) ? ctr : ctr - CTR_BITS'(1);
  endfunction

  logic [CTR_BITS-1:0] pht [DEPTH];
  logic [BH_SIZE-1:0]  ghr;
  logic [BH_SIZE-1:0]  pidx;
  logic [BH_SIZE-1:0]  uidx;
  logic [CTR_BITS-1:0] upd_ctr_next;
  logic [CTR_BITS-1:0] pred_ctr;
  logic                squash;

  // Only the hashed PC window matters; fold the rest so it reads as used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc, upd_pc};

  assign pidx         = ghr ^ pred_pc[PC_LSB+BH_SIZE-1:PC_LSB];
  assign uidx         = upd_ghr ^ upd_pc[PC_LSB+BH_SIZE-1:PC_LSB];
  assign upd_ctr_next = ctr_step(pht[uidx], upd_taken);

  // A retire-time mispredict repairs the GHR and kills any fetch this cycle,
  // since that fetch was made on the wrong path.
  assign squash = upd_en & upd_mispredict;

`ifdef GSHARE_CTR_BYPASS_EN
  assign pred_ctr = (upd_en && (pidx == uidx)) ? upd_ctr_next : pht[pidx];
`else
  assign pred_ctr = pht[pidx];
`endif

  assign pred_valid = pred_en & ~reset & ~squash;
  assign pred_taken = pred_valid & pred_ctr[CTR_BITS-1];
  assign pred_ghr   = ghr;
  assign ghr_out    = ghr;

  // GHR: repair beats speculative shift; reset beats both.
  always_ff @(posedge clock) begin
    if (reset) begin
      ghr <= '0;
    end else if (squash) begin
      ghr <= {upd_ghr[BH_SIZE-2:0], upd_taken};
    end else if (pred_valid) begin
      ghr <= {ghr[BH_SIZE-2:0], pred_taken};
    end
  end

  // PHT: trained on every retired branch, mispredicted or not.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pht[i] <= CTR_WNT;
    end else if (upd_en) begin
      pht[uidx] <= upd_ctr_next;
    end
  end

endmodule

// File: tb/tb_gshare_ctr.sv
// tb_gshare_ctr: directed and randomized bench for gshare_ctr (default params).
// A reference model (integer counter table plus integer history) predicts every
// output each cycle; directed steps also check known constant values.
module tb_gshare_ctr;

  logic        clock = 1'b0;
  logic        reset;
  logic        pred_en;
  logic [31:0] pred_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [7:0]  pred_ghr;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [7:0]  upd_ghr;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [7:0]  ghr_out;

  gshare_ctr #(.BH_SIZE(8), .CTR_BITS(2), .PC_LSB(2)) dut (
    .clock(clock), .reset(reset),
    .pred_en(pred_en), .pred_pc(pred_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .ghr_out(ghr_out)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: counters as integers 0..3, history as an integer 0..255.
  int m_pht [256];
  int m_ghr;

  // Observed combinational outputs from the most recent cycle.
  logic s_pv, s_pt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    m_ghr = 0;
  endtask

  function automatic int trained(input int c, input bit up);
    if (up) return (c < 3) ? c + 1 : 3;
    else    return (c > 0) ? c - 1 : 0;
  endfunction

  // One clock: drive, check combinational outputs, clock, check GHR.
  task automatic do_cycle(input bit rst, input bit pe, input logic [31:0] ppc,
                          input bit ue, input logic [31:0] upc, input logic [7:0] ughr,
                          input bit ut, input bit um);
    int  pidx, uidx, cval, e_ghr;
    bit  e_pv, e_pt;
    @(negedge clock);
    reset = rst; pred_en = pe; pred_pc = ppc;
    upd_en = ue; upd_pc = upc; upd_ghr = ughr; upd_taken = ut; upd_mispredict = um;
    #1;
    pidx = (m_ghr ^ int'(ppc >> 2)) & 255;
    uidx = (int'(ughr) ^ int'(upc >> 2)) & 255;
    e_pv = pe && !rst && !(ue && um);
    cval = m_pht[pidx];
`ifdef GSHARE_CTR_BYPASS_EN
    if (ue && pidx == uidx) cval = trained(cval, ut);
`endif
    e_pt = e_pv && (cval >= 2);
    s_pv = pred_valid;
    s_pt = pred_taken;
    chk("pred_valid", 32'(pred_valid), 32'(e_pv));
    chk("pred_taken", 32'(pred_taken), 32'(e_pt));
    chk("pred_ghr", 32'(pred_ghr), 32'(m_ghr));
    if (rst) begin
      model_reset();
    end else begin
      if (ue) m_pht[uidx] = trained(m_pht[uidx], ut);
      e_ghr = m_ghr;
      if (ue && um)  e_ghr = ((int'(ughr) << 1) | int'(ut)) & 255;
      else if (e_pv) e_ghr = ((m_ghr << 1) | int'(e_pt)) & 255;
      m_ghr = e_ghr;
    end
    @(posedge clock);
    #1;
    chk("ghr_out", 32'(ghr_out), 32'(m_ghr));
  endtask

  task automatic predict(input logic [31:0] pc);
    do_cycle(0, 1, pc, 0, 0, 0, 0, 0);
  endtask

  // PC whose hash with the current model history lands on idx.
  function automatic logic [31:0] pc_for(input int idx);
    return 32'(((idx ^ m_ghr) & 255) << 2);
  endfunction

  task automatic retire(input logic [31:0] pc, input bit t);
    do_cycle(0, 0, 0, 1, pc, 8'h00, t, 0);
  endtask

  // Rebuild GHR to 0 via a repair; trains index 0xFF down as a side effect.
  task automatic ghr_zero();
    do_cycle(0, 0, 0, 1, 32'h3FC, 8'h00, 0, 1);
  endtask

  initial begin
    reset = 1; pred_en = 0; pred_pc = 0;
    upd_en = 0; upd_pc = 0; upd_ghr = 0; upd_taken = 0; upd_mispredict = 0;
    @(posedge clock); #1;
    model_reset();

    // Reset held with a fetch request: nothing valid.
    do_cycle(1, 1, 32'h40, 0, 0, 0, 0, 0);
    chk("rst_pv", 32'(s_pv), 0);
    chk("rst_ghr", 32'(ghr_out), 0);

    // First prediction after reset.
    predict(32'h40);
    chk("post_rst_pv", 32'(s_pv), 1);
    chk("post_rst_pt", 32'(s_pt), 0);
    chk("post_rst_ghr", 32'(ghr_out), 8'h00);

    // Training 01 -> 10 at index 0x10, then predict with GHR = 0.
    retire(32'h40, 1);
    ghr_zero();
    predict(32'h40);
    chk("train_pt", 32'(s_pt), 1);

    // Saturation at index 0x20 (pc 0x80, ghr snapshot 0).
    for (int i = 0; i < 5; i++) retire(32'h80, 1);
    retire(32'h80, 0);
    predict(pc_for(8'h20));
    chk("sat_hi_pt", 32'(s_pt), 1);
    retire(32'h80, 0);
    retire(32'h80, 0);
    predict(pc_for(8'h20));
    chk("sat_00_pt", 32'(s_pt), 0);
    retire(32'h80, 0);
    retire(32'h80, 1);
    predict(pc_for(8'h20));
    chk("sat_lo_pt", 32'(s_pt), 0);
    retire(32'h80, 1);
    predict(pc_for(8'h20));
    chk("sat_lo_up_pt", 32'(s_pt), 1);

    // History shift 1, 0, 1 from GHR = 0.
    ghr_zero();
    predict(32'h40);
    chk("hist_1", 32'(ghr_out), 8'h01);
    predict(32'h400);
    chk("hist_2", 32'(ghr_out), 8'h02);
    predict(32'h48);
    chk("hist_3", 32'(ghr_out), 8'h05);

    // Mispredict squash with a simultaneous fetch.
    do_cycle(0, 1, 32'h40, 1, 32'h100, 8'h3C, 1, 1);
    chk("squash_pv", 32'(s_pv), 0);
    chk("squash_ghr", 32'(ghr_out), 8'h79);

    // Same-index collision at index 0x33 (counter 01).
    do_cycle(0, 1, pc_for(8'h33), 1, 32'hCC, 8'h00, 1, 0);
`ifdef GSHARE_CTR_BYPASS_EN
    chk("collide_pt", 32'(s_pt), 1);
`else
    chk("collide_pt", 32'(s_pt), 0);
`endif
    predict(pc_for(8'h33));
    chk("collide_after_pt", 32'(s_pt), 1);

    // Reset mid-operation overrides a same-cycle repair and training.
    do_cycle(1, 1, 32'h40, 1, 32'h40, 8'hAA, 1, 1);
    chk("midrst_ghr", 32'(ghr_out), 0);
    predict(32'h40);
    chk("midrst_pt", 32'(s_pt), 0);

    // Randomized traffic against the model, with frequent index collisions.
    for (int i = 0; i < 400; i++) begin
      bit          r_rst, r_pe, r_ue, r_ut, r_um;
      logic [31:0] r_ppc, r_upc;
      logic [7:0]  r_ughr;
      r_rst  = ($urandom_range(0, 79) == 0);
      r_pe   = ($urandom_range(0, 3) != 0);
      r_ue   = ($urandom_range(0, 1) == 1);
      r_ut   = $urandom_range(0, 1);
      r_um   = ($urandom_range(0, 4) == 0);
      r_ppc  = {$urandom_range(0, 65535), 8'h00, 8'h00} | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      r_upc  = ($urandom_range(0, 2) == 0) ? r_ppc : (32'($urandom_range(0, 15) << 2) | 32'h1234_0000);
      r_ughr = ($urandom_range(0, 1) == 0) ? 8'(m_ghr) : 8'($urandom_range(0, 7));
      do_cycle(r_rst, r_pe, r_ppc, r_ue, r_upc, r_ughr, r_ut, r_um);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
